cordic_host_link: RTL and testbench

CORDIC_HOST_LINK -- requirements
Module: cordic_host_link

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_tag_lut.sv | 25 ++
 rtl/cordic_host_link.sv | 199 +++++++++++++++++++
 tb/tb_cordic_host_link.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC host link: mode codes, result tags,
// 48-bit FIFO word layout and the link FSM states.
package cordic_pkg;

  localparam logic [7:0] MODE_1  = 8'd1;
  localparam logic [7:0] MODE_2  = 8'd2;
  localparam logic [7:0] MODE_3  = 8'd3;
  localparam logic [7:0] MODE_4  = 8'd4;
  localparam logic [7:0] MODE_5  = 8'd5;
  localparam logic [7:0] MODE_6  = 8'd6;
  localparam logic [7:0] MODE_7  = 8'd7;
  localparam logic [7:0] MODE_8  = 8'd8;
  localparam logic [7:0] MODE_9  = 8'd9;
  localparam logic [7:0] MODE_10 = 8'd10;
  localparam logic [7:0] MODE_11 = 8'd11;

  localparam logic [15:0] TAG_A = 16'h000A;
  localparam logic [15:0] TAG_B = 16'h000B;
  localparam logic [15:0] TAG_C = 16'h000C;
  localparam logic [15:0] TAG_D = 16'h000D;
  localparam logic [15:0] TAG_E = 16'h000E;
  localparam logic [15:0] TAG_F = 16'h000F;

  localparam int WORD_W   = 48;
  localparam int TAG_MSB  = 47;
  localparam int TAG_LSB  = 32;
  localparam int MODE_MSB = 39;
  localparam int MODE_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_X,
    PUSH_Y,
    WAIT_RES,
    RD_HOLD,
    SAMPLE,
    OUT
  } state_e;

  function automatic logic [WORD_W-1:0] make_cmd_word(input logic [7:0]  mode,
                                                      input logic [31:0] operand);
    return {8'h00, mode, operand};
  endfunction

endpackage

// File: rtl/cordic_tag_lut.sv
// Combinational map from CORDIC mode to the result tag the engine returns,
// plus a flag telling whether the mode is one the engine understands.
module cordic_tag_lut
  import cordic_pkg::*;
(
  input  logic [7:0]  mode,
  output logic [15:0] exp_tag,
  output logic        legal
);

  always_comb begin
    exp_tag = 16'h0000;
    legal   = 1'b1;
    case (mode)
      MODE_1, MODE_2, MODE_4:  exp_tag = TAG_A;
      MODE_3, MODE_8:          exp_tag = TAG_B;
      MODE_9, MODE_10, MODE_11: exp_tag = TAG_C;
      MODE_7:                  exp_tag = TAG_D;
      MODE_5:                  exp_tag = TAG_E;
      MODE_6:                  exp_tag = TAG_F;
      default:                 legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/cordic_host_link.sv
// Host-side link to a FIFO-attached CORDIC engine: pushes one or two command
// words, reads back the tagged result and presents it on a valid/ready port.
// Optional result-wait timeout is enabled by defining CORDIC_HOST_TIMEOUT_EN.
module cordic_host_link
  import cordic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_mode,
  input  logic [31:0] cmd_x,
  input  logic [31:0] cmd_y,
  input  logic        cmd_full,
  output logic        cmd_wr_en,
  output logic [47:0] cmd_wr_data,
  input  logic        res_empty,
  output logic        res_rd_en,
  input  logic [47:0] res_rd_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        res_timeout,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [7:0]         mode_q, mode_d;
  logic [31:0]        y_q, y_d;
  logic [15:0]        exp_tag_q, exp_tag_d;
  logic [WORD_W-1:0]  cmd_wr_data_q, cmd_wr_data_d;
  logic [WORD_W-1:0]  sample_q, sample_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic               res_valid_q, res_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               cmd_wr_en_c, res_rd_en_c;
  logic [15:0]        lut_tag;
  logic               lut_legal;

`ifdef CORDIC_HOST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_timeout_q, res_timeout_d;
`endif

  // Legality and expected tag are decided from the incoming mode at acceptance
  cordic_tag_lut u_tag_lut (
    .mode    (cmd_mode),
    .exp_tag (lut_tag),
    .legal   (lut_legal)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    y_d           = y_q;
    exp_tag_d     = exp_tag_q;
    cmd_wr_data_d = cmd_wr_data_q;
    sample_d      = sample_q;
    res_data_d    = res_data_q;
    res_err_d     = res_err_q;
    cmd_wr_en_c   = 1'b0;
    res_rd_en_c   = 1'b0;
`ifdef CORDIC_HOST_TIMEOUT_EN
    res_timeout_d = res_timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          mode_d    = cmd_mode;
          y_d       = cmd_y;
          exp_tag_d = lut_tag;
`ifdef CORDIC_HOST_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          if (lut_legal) begin
            cmd_wr_data_d = make_cmd_word(cmd_mode, cmd_x);
            state_d       = PUSH_X;
          end else begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = OUT;
          end
        end
      end
      PUSH_X: begin
        if (!cmd_full) begin
          cmd_wr_en_c = 1'b1;
          if (mode_q == MODE_8) begin
            cmd_wr_data_d = make_cmd_word(mode_q, y_q);
            state_d       = PUSH_Y;
          end else begin
            state_d = WAIT_RES;
          end
        end
      end
      PUSH_Y: begin
        if (!cmd_full) begin
          cmd_wr_en_c = 1'b1;
          state_d     = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (!res_empty) begin
          res_rd_en_c = 1'b1;
          state_d     = RD_HOLD;
        end
`ifdef CORDIC_HOST_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_timeout_d = 1'b1;
          res_err_d     = 1'b0;
          res_data_d    = '0;
          state_d       = OUT;
        end
`endif
      end
      // The FIFO read data is only valid in the cycle after the strobe
      RD_HOLD: begin
        sample_d = res_rd_data;
        state_d  = SAMPLE;
      end
      SAMPLE: begin
        res_data_d = sample_q[DATA_MSB:DATA_LSB];
        res_err_d  = (sample_q[TAG_MSB:TAG_LSB] != exp_tag_q);
        state_d    = OUT;
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == OUT);

`ifdef CORDIC_HOST_TIMEOUT_EN
    cnt_d = ((state_q == WAIT_RES) && (state_d == WAIT_RES)) ? cnt_q + CNT_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= '0;
      y_q           <= '0;
      exp_tag_q     <= '0;
      cmd_wr_data_q <= '0;
      sample_q      <= '0;
      res_data_q    <= '0;
      res_err_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef CORDIC_HOST_TIMEOUT_EN
      cnt_q         <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      y_q           <= y_d;
      exp_tag_q     <= exp_tag_d;
      cmd_wr_data_q <= cmd_wr_data_d;
      sample_q      <= sample_d;
      res_data_q    <= res_data_d;
      res_err_q     <= res_err_d;
      res_valid_q   <= res_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
`ifdef CORDIC_HOST_TIMEOUT_EN
      cnt_q         <= cnt_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  // FIFO strobes must follow the live full/empty flags, so they stay combinational
  assign cmd_wr_en   = cmd_wr_en_c & ~reset;
  assign res_rd_en   = res_rd_en_c & ~reset;
  assign cmd_wr_data = cmd_wr_data_q;
  assign cmd_ready   = cmd_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign busy        = busy_q;
`ifdef CORDIC_HOST_TIMEOUT_EN
  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_host_link.sv
// Scoreboard bench for cordic_host_link: expected FIFO writes and host results
// are queued by the stimulus and checked by independent negedge monitors.
module tb_cordic_host_link;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_mode = '0;
  logic [31:0] cmd_x = '0;
  logic [31:0] cmd_y = '0;
  logic        cmd_full = 1'b0;
  logic        cmd_wr_en;
  logic [47:0] cmd_wr_data;
  logic        res_empty = 1'b1;
  logic        res_rd_en;
  logic [47:0] res_rd_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        to;
  } res_t;

  typedef struct {
    logic [7:0]  mode;
    logic [31:0] x;
    logic [31:0] y;
    logic        two_words;
    logic [47:0] wr_x;
    logic [47:0] wr_y;
    logic [47:0] res_word;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic [47:0] exp_wr[$];
  res_t        exp_res[$];
  logic [47:0] res_mem[$];
  vec_t        vecs[11];

  logic        load_req = 1'b0;
  logic [47:0] load_word = '0;
  int          cyc = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          rd_cyc = 0;
  bit          rd_pending = 1'b0;
  logic [86:0] all_outs;

  assign all_outs = {cmd_ready, cmd_wr_en, cmd_wr_data, res_rd_en, res_valid,
                     res_data, res_err, res_timeout, busy};

  cordic_host_link #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_full    (cmd_full),
    .cmd_wr_en   (cmd_wr_en),
    .cmd_wr_data (cmd_wr_data),
    .res_empty   (res_empty),
    .res_rd_en   (res_rd_en),
    .res_rd_data (res_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result FIFO model: read data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (res_rd_en && res_mem.size() > 0) res_rd_data <= res_mem.pop_front();
    if (load_req) res_mem.push_back(load_word);
    res_empty <= (res_mem.size() == 0);
  end

  // Monitors: command writes, result reads and host handshakes
  always @(negedge clk) begin
    if (reset) begin
      rd_pending = 1'b0;
    end else begin
      if (cmd_wr_en) begin
        wr_count++;
        checkOutput("wr_while_full", 128'(cmd_full), 128'(0));
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL wr_unexpected: got %0h, expected no write", cmd_wr_data);
        end else begin
          checkOutput("wr_word", 128'(cmd_wr_data), 128'(exp_wr.pop_front()));
        end
      end
      if (res_valid && rd_pending) begin
        checkOutput("rd_to_valid_latency", 128'(cyc - rd_cyc), 128'(3));
        rd_pending = 1'b0;
      end
      if (res_rd_en) begin
        rd_count++;
        checkOutput("rd_while_empty", 128'(res_empty), 128'(0));
        rd_pending = 1'b1;
        rd_cyc     = cyc;
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL res_unexpected: got %0h, expected no result",
                   {res_data, res_err, res_timeout});
        end else begin
          checkOutput("res_word", 128'({res_data, res_err, res_timeout}),
                      128'(exp_res.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] mode, input logic [31:0] x,
                               input logic [31:0] y);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 128'(cmd_ready), 128'(1));
      return;
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_x     = x;
    cmd_y     = y;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic loadResult(input logic [47:0] w);
    load_word = w;
    load_req  = 1'b1;
    tick();
    load_req  = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || res_valid) && n < 300) begin
      tick();
      n++;
    end
    if (busy || res_valid) checkOutput(name, 128'({busy, res_valid}), 128'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wc;
    int rc;
    int n;

    vecs[0]  = '{8'd1,  32'h0000_4000, 32'h0, 1'b0, 48'h00_01_0000_4000, 48'h0,
                 48'h000A_1234_5678, 32'h1234_5678, 1'b0};
    vecs[1]  = '{8'd8,  32'h0000_0010, 32'h0000_0020, 1'b1, 48'h00_08_0000_0010,
                 48'h00_08_0000_0020, 48'h000B_0000_0030, 32'h0000_0030, 1'b0};
    vecs[2]  = '{8'd9,  32'h0000_0099, 32'h0, 1'b0, 48'h00_09_0000_0099, 48'h0,
                 48'h000A_DEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{8'd5,  32'h0000_0005, 32'h0, 1'b0, 48'h00_05_0000_0005, 48'h0,
                 48'h000E_0000_0505, 32'h0000_0505, 1'b0};
    vecs[4]  = '{8'd6,  32'h0000_0006, 32'h0, 1'b0, 48'h00_06_0000_0006, 48'h0,
                 48'h000F_0000_0606, 32'h0000_0606, 1'b0};
    vecs[5]  = '{8'd7,  32'h0000_0007, 32'h0, 1'b0, 48'h00_07_0000_0007, 48'h0,
                 48'h000D_0000_0707, 32'h0000_0707, 1'b0};
    vecs[6]  = '{8'd11, 32'hA5A5_A5A5, 32'h0, 1'b0, 48'h00_0B_A5A5_A5A5, 48'h0,
                 48'h000C_5A5A_5A5A, 32'h5A5A_5A5A, 1'b0};
    vecs[7]  = '{8'd2,  32'h0000_0002, 32'h0, 1'b0, 48'h00_02_0000_0002, 48'h0,
                 48'h000A_0000_0202, 32'h0000_0202, 1'b0};
    vecs[8]  = '{8'd10, 32'h0000_0010, 32'h0, 1'b0, 48'h00_0A_0000_0010, 48'h0,
                 48'h000B_0000_1010, 32'h0000_1010, 1'b1};
    vecs[9]  = '{8'd4,  32'hFFFF_FFFF, 32'h0, 1'b0, 48'h00_04_FFFF_FFFF, 48'h0,
                 48'h000A_FFFF_0000, 32'hFFFF_0000, 1'b0};
    vecs[10] = '{8'd8,  32'h0000_0001, 32'h0000_0002, 1'b1, 48'h00_08_0000_0001,
                 48'h00_08_0000_0002, 48'h000A_0000_0808, 32'h0000_0808, 1'b1};

    // Reset values and first ready cycle
    repeat (3) tick();
    checkOutput("reset_outputs", 128'(all_outs), 128'(0));
    reset = 1'b0;
    tick();
    checkOutput("ready_after_reset", 128'({cmd_ready, busy}), 128'(2'b10));

    // Directed vectors through the full push / read path
    foreach (vecs[i]) begin
      exp_wr.push_back(vecs[i].wr_x);
      if (vecs[i].two_words) exp_wr.push_back(vecs[i].wr_y);
      exp_res.push_back({vecs[i].data, vecs[i].err, 1'b0});
      applyStimulus(vecs[i].mode, vecs[i].x, vecs[i].y);
      checkOutput("busy_after_accept", 128'({busy, cmd_ready}), 128'(2'b10));
      loadResult(vecs[i].res_word);
      waitIdle("vector_done");
    end

    // Command FIFO full for 5 cycles in PUSH_X, with a competing command ignored
    wc = wr_count;
    cmd_full = 1'b1;
    exp_wr.push_back(48'h00_03_0000_0333);
    exp_res.push_back({32'h0000_0333, 1'b0, 1'b0});
    applyStimulus(8'd3, 32'h0000_0333, 32'h0);
    cmd_valid = 1'b1;
    cmd_mode  = 8'd1;
    cmd_x     = 32'h0000_1111;
    repeat (5) tick();
    checkOutput("busy_ignores_cmd", 128'({cmd_ready, busy}), 128'(2'b01));
    checkOutput("no_wr_while_full", 128'(wr_count - wc), 128'(0));
    cmd_valid = 1'b0;
    cmd_full  = 1'b0;
    loadResult(48'h000B_0000_0333);
    waitIdle("full_done");
    checkOutput("one_wr_after_full", 128'(wr_count - wc), 128'(1));

    // Illegal modes: immediate error result, no FIFO traffic, stable while stalled
    wc = wr_count;
    rc = rd_count;
    res_ready = 1'b0;
    exp_res.push_back({32'h0, 1'b1, 1'b0});
    applyStimulus(8'd0, 32'h0000_1234, 32'h0000_5678);
    checkOutput("illegal_valid_next_cycle", 128'(res_valid), 128'(1));
    repeat (3) begin
      tick();
      checkOutput("illegal_hold", 128'({res_valid, res_data, res_err, res_timeout, busy}),
                  128'({1'b1, 32'h0, 1'b1, 1'b0, 1'b1}));
    end
    res_ready = 1'b1;
    waitIdle("illegal_done");
    exp_res.push_back({32'h0, 1'b1, 1'b0});
    applyStimulus(8'd12, 32'h0000_00CC, 32'h0);
    waitIdle("illegal12_done");
    checkOutput("illegal_no_strobes", 128'({wr_count - wc, rd_count - rc}), 128'(0));

    // Reset in the middle of a push aborts without writing
    wc = wr_count;
    cmd_full = 1'b1;
    applyStimulus(8'd1, 32'h0000_0077, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checkOutput("reset_midpush_outputs", 128'(all_outs), 128'(0));
    cmd_full = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("ready_after_midpush_reset", 128'({cmd_ready, busy}), 128'(2'b10));
    checkOutput("midpush_no_write", 128'(wr_count - wc), 128'(0));

    // Reset while waiting for a result
    exp_wr.push_back(48'h00_02_0000_0022);
    applyStimulus(8'd2, 32'h0000_0022, 32'h0);
    repeat (4) tick();
    checkOutput("waiting_for_result", 128'({busy, res_valid, res_rd_en}), 128'(3'b100));
    reset = 1'b1;
    tick();
    checkOutput("reset_wait_outputs", 128'(all_outs), 128'(0));
    reset = 1'b0;
    tick();
    checkOutput("ready_after_wait_reset", 128'({cmd_ready, busy}), 128'(2'b10));

    // Normal transaction after the aborts
    exp_wr.push_back(48'h00_01_0000_4000);
    exp_res.push_back({32'h1234_5678, 1'b0, 1'b0});
    applyStimulus(8'd1, 32'h0000_4000, 32'h0);
    loadResult(48'h000A_1234_5678);
    waitIdle("recovery_done");

`ifdef CORDIC_HOST_TIMEOUT_EN
    // One PUSH_X cycle plus 16 WAIT_RES cycles before OUT is registered
    exp_wr.push_back(48'h00_01_0000_00AA);
    exp_res.push_back({32'h0, 1'b0, 1'b1});
    applyStimulus(8'd1, 32'h0000_00AA, 32'h0);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    checkOutput("timeout_latency", 128'(n), 128'(17));
    checkOutput("timeout_flags", 128'({res_timeout, res_err, res_data}), 128'({1'b1, 1'b0, 32'h0}));
    waitIdle("timeout_done");
`endif

    checkOutput("writes_drained", 128'(exp_wr.size()), 128'(0));
    checkOutput("results_drained", 128'(exp_res.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
